// File: rtl/alu.sv
// alu: 4-bit registered arithmetic/logic unit, eight ops on {sel2,sel1,sel0}
module alu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       sel0,
  input  logic       sel1,
  input  logic       sel2,
  input  logic       enable,
  output logic [3:0] out,
  output logic       cout
);
  logic [4:0] r;
  // Subtract in 5 bits: the range -16..15 fits, so bit 4 is the borrow
  always_comb begin
    r = '0;
    case ({sel2, sel1, sel0})
      3'd0: r = {1'b0, a} + {1'b0, b} + {4'b0, cin};
      3'd1: r = {1'b0, a} - {1'b0, b} - {4'b0, cin};
      3'd2: r = {1'b0, a & b};
      3'd3: r = {1'b0, a | b};
      3'd4: r = {1'b0, a ^ b};
      3'd5: r = {1'b0, ~a};
      3'd6: r = {a, cin};
      default: r = {a[0], cin, a[3:1]};
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) {cout, out} <= '0;
    else if (enable) {cout, out} <= r;
  end
endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboarded random and directed test of alu against an arithmetic reference
module tb_alu;
  logic clk = 0, rst_n = 0, enable = 1, cin = 0, sel0 = 0, sel1 = 0, sel2 = 0;
  logic [3:0] a = 0, b = 0, out;
  logic cout;
  bit dir_on = 0;
  logic [4:0] dir_want = 0;
  logic [4:0] held = 0;
  int total = 0, bad = 0;
  typedef struct {logic [4:0] m; bit d; logic [4:0] w;} exp_t;
  exp_t q[$];

  alu dut (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .sel0(sel0),
           .sel1(sel1), .sel2(sel2), .enable(enable), .out(out), .cout(cout));

  always #5 clk = ~clk;

  function automatic logic [4:0] ref_op(int x, int y, int c, int op);
    int v, f;
    f = 0;
    case (op)
      0: begin v = x + y + c; f = (v > 15) ? 1 : 0; v = v % 16; end
      1: begin v = x - y - c; f = (v < 0) ? 1 : 0; v = (v + 16) % 16; end
      2: v = x & y;
      3: v = x | y;
      4: v = x ^ y;
      5: v = 15 - x;
      6: begin v = (x * 2 + c) % 16; f = x / 8; end
      default: begin v = c * 8 + x / 2; f = x % 2; end
    endcase
    return 5'(f * 16 + v);
  endfunction

  function automatic logic [4:0] model_next();
    if (!rst_n) return 5'd0;
    if (!enable) return held;
    return ref_op(int'(a), int'(b), int'(cin), int'({sel2, sel1, sel0}));
  endfunction

  always @(posedge clk) begin
    q.push_back('{m: model_next(), d: dir_on, w: dir_want});
    held <= model_next();
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL sb_empty: no expectation queued, got out=%0d cout=%0d", out, cout);
    end else begin
      e = q.pop_front();
      if ({cout, out} !== e.m) begin
        bad++;
        $display("FAIL model: got out=%0d cout=%0d want out=%0d cout=%0d", out, cout, e.m[3:0], e.m[4]);
      end
      if (e.d) begin
        total++;
        if ({cout, out} !== e.w) begin
          bad++;
          $display("FAIL directed: got out=%0d cout=%0d want out=%0d cout=%0d", out, cout, e.w[3:0], e.w[4]);
        end
      end
    end
  end

  task automatic drive(input bit r, input bit en, input int x, input int y, input int c,
                       input int op, input bit d = 0, input int wo = 0, input int wc = 0);
    @(negedge clk);
    rst_n = r; enable = en; a = 4'(x); b = 4'(y); cin = c[0];
    {sel2, sel1, sel0} = 3'(op);
    dir_on = d; dir_want = {wc[0], 4'(wo)};
  endtask

  int sweep_o[8] = '{1, 7, 4, 13, 9, 3, 8, 6};
  int sweep_c[8] = '{1, 0, 0, 0, 0, 0, 1, 0};

  initial begin
    drive(0, 1, 12, 5, 0, 0, 1, 0, 0);
    drive(0, 1, 12, 5, 0, 0, 1, 0, 0);
    drive(1, 1, 12, 5, 0, 0, 1, 1, 1);
    for (int i = 0; i < 8; i++) drive(1, 1, 12, 5, 0, i, 1, sweep_o[i], sweep_c[i]);
    drive(1, 1, 15, 0, 1, 0, 1, 0, 1);
    drive(1, 1, 3, 3, 1, 1, 1, 15, 1);
    drive(1, 1, 5, 0, 1, 6, 1, 11, 0);
    drive(1, 1, 5, 0, 1, 7, 1, 10, 1);
    drive(1, 1, 12, 5, 0, 1, 1, 7, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 5, 0, 2, 1, 7, 0);
    drive(1, 1, 0, 5, 0, 2, 1, 0, 0);
    drive(1, 1, 12, 5, 0, 0, 1, 1, 1);
    drive(0, 1, 12, 5, 0, 0, 1, 0, 0);
    drive(1, 1, 12, 5, 0, 1, 1, 7, 0);
    for (int op = 0; op < 8; op++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          for (int c = 0; c < 2; c++) drive(1, 1, x, y, c, op);
    for (int i = 0; i < 600; i++)
      drive(($urandom_range(15) != 0), $urandom_range(1), $urandom_range(15),
            $urandom_range(15), $urandom_range(1), $urandom_range(7));
    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
